composite_ecc_pipe: RTL

//  Pipelined, parametrised SECDED (extended Hamming) encode -> fault-inject -> decode datapath for the memory ECC subsystem.

---
 rtl/composite_ecc_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/composite_ecc_pipe.sv
// Two-stage SECDED (extended Hamming) pipeline: encode + fault inject + syndrome in stage 1,
// classify/correct in stage 2, with valid/ready handshake and saturating error counters.
module composite_ecc_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int CORRECT_EN  = 1,
  parameter int COUNT_WIDTH = 8,
  localparam int R0 = $clog2(DATA_WIDTH + 1),
  localparam int R  = ((2 ** R0) >= (DATA_WIDTH + R0 + 1)) ? R0 : R0 + 1,
  localparam int CW = DATA_WIDTH + R + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CW-1:0]          inj_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   err_single,
  output logic                   err_double,
  output logic [R-1:0]           err_syn,
  output logic [COUNT_WIDTH-1:0] ce_count,
  output logic [COUNT_WIDTH-1:0] ue_count,
  input  logic                   clr_counts
);

  localparam bit DO_FIX = (CORRECT_EN != 0);
  localparam logic [R:0] CW_LIM = (R + 1)'(CW);

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] c;
    logic          p;
    int            k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int j = 0; j < R; j++) begin
      p = 1'b0;
      for (int pos = 1; pos < CW; pos++) begin
        if (pos[j] && !is_pow2(pos)) p = p ^ c[pos];
      end
      c[1 << j] = p;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [R-1:0] syndrome(input logic [CW-1:0] rx);
    logic [R-1:0] s;
    s = '0;
    for (int j = 0; j < R; j++) begin
      for (int pos = 1; pos < CW; pos++) begin
        if (pos[j]) s[j] = s[j] ^ rx[pos];
      end
    end
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] rx);
    logic [DATA_WIDTH-1:0] d;
    int                    k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (!is_pow2(pos)) begin
        d[k] = rx[pos];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                  advance;
  logic [CW-1:0]         rx_p0;
  logic                  vld_p1;
  logic [CW-1:0]         cw_p1;
  logic [R-1:0]          syn_p1;
  logic                  par_p1;
  logic                  in_range;
  logic                  is_single;
  logic                  is_double;
  logic [CW-1:0]         fix_mask;
  logic [DATA_WIDTH-1:0] data_fix;

  // Whole pipeline stalls together; stage 1 may still fill a bubble while the output is held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance || !vld_p1;
  assign rx_p0    = encode(in_data) ^ inj_mask;

  // ---- stage 1: encode, inject, syndrome ----
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready) begin
      cw_p1  <= rx_p0;
      syn_p1 <= syndrome(rx_p0);
      par_p1 <= ^rx_p0;
    end
  end

  // ---- stage 2: classify and correct ----
  assign in_range  = ({1'b0, syn_p1} < CW_LIM);
  assign is_single = par_p1 && in_range;
  assign is_double = par_p1 ? !in_range : (syn_p1 != '0);

  // Syndrome 0 with overall mismatch means only bit 0 flipped: no data position touched.
  always_comb begin
    fix_mask = '0;
    for (int p = 1; p < CW; p++) begin
      if (syn_p1 == R'(p)) fix_mask[p] = 1'b1;
    end
  end

  assign data_fix = extract(cw_p1 ^ ((DO_FIX && is_single) ? fix_mask : '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      err_syn    <= '0;
    end else if (advance) begin
      out_valid  <= vld_p1;
      out_data   <= data_fix;
      err_single <= vld_p1 && is_single;
      err_double <= vld_p1 && is_double;
      err_syn    <= syn_p1;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_counts) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (advance && vld_p1) begin
      if (is_single) ce_count <= sat_inc(ce_count);
      if (is_double) ue_count <= sat_inc(ue_count);
    end
  end

endmodule
